// File: rtl/descriptor_reader.sv
// descriptor_reader
//   Reads keypoint descriptors back from the descriptor BRAM. Each keypoint
//   occupies SUBPATCHES consecutive W-bit histogram words; this block fetches
//   them in order, packs each group into one D-bit descriptor (sub-patch 0 in
//   the low bits) and offers it on a valid/ready stream. Trailing words that
//   do not form a complete group are never read.
//
// Ports
//   clk            system clock
//   rst_in         asynchronous active-high reset
//   start          one-cycle pulse starting a readout pass (honoured in IDLE only)
//   desc_count     number of valid BRAM words, sampled on start
//   desc_read_addr BRAM read address
//   desc_read      BRAM read data, READ_LATENCY cycles after the address
//   desc_valid     desc_data holds a complete descriptor
//   desc_ready     downstream accepts the descriptor
//   desc_data      packed descriptor
//   desc_index     0-based index of the descriptor on desc_data
//   busy           high whenever the FSM is not in IDLE
//   done           one-cycle pulse marking the end of a pass
module descriptor_reader #(
   parameter int NUMBER_DESCRIPTORS = 4000,
   parameter int BIN_WIDTH          = 3,
   parameter int NUM_BINS           = 8,
   parameter int SUBPATCHES         = 4,
   parameter int READ_LATENCY       = 2
) (
   input  logic                                                clk,
   input  logic                                                rst_in,
   input  logic                                                start,
   input  logic [$clog2(NUMBER_DESCRIPTORS)-1:0]               desc_count,
   output logic [$clog2(NUMBER_DESCRIPTORS)-1:0]               desc_read_addr,
   input  logic [BIN_WIDTH*NUM_BINS-1:0]                       desc_read,
   output logic                                                desc_valid,
   input  logic                                                desc_ready,
   output logic [BIN_WIDTH*NUM_BINS*SUBPATCHES-1:0]            desc_data,
   output logic [$clog2(NUMBER_DESCRIPTORS/SUBPATCHES)-1:0]    desc_index,
   output logic                                                busy,
   output logic                                                done
);

   localparam int AW  = $clog2(NUMBER_DESCRIPTORS);
   localparam int W   = BIN_WIDTH * NUM_BINS;
   localparam int SW  = $clog2(SUBPATCHES);
   localparam int WCW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

   // Words needed past the current base for a further complete group.
   localparam logic [AW:0] NEXT_SPAN = (AW+1)'(2 * SUBPATCHES);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE,
      OUTPUT,
      FINISH
   } state_t;

   state_t           state;
   logic [AW-1:0]    count_q;
   logic [AW-1:0]    base_q;
   logic [SW-1:0]    slot_q;
   logic [WCW-1:0]   wait_q;

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         state          <= IDLE;
         count_q        <= '0;
         base_q         <= '0;
         slot_q         <= '0;
         wait_q         <= '0;
         desc_read_addr <= '0;
         desc_valid     <= 1'b0;
         desc_data      <= '0;
         desc_index     <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  count_q        <= desc_count;
                  base_q         <= '0;
                  slot_q         <= '0;
                  desc_index     <= '0;
                  // Address is loaded on entry to ISSUE so it is on the bus
                  // during the ISSUE cycle itself.
                  desc_read_addr <= '0;
                  busy           <= 1'b1;
                  if (desc_count < AW'(SUBPATCHES)) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end

            ISSUE: begin
               wait_q <= '0;
               if (READ_LATENCY > 1) state <= WAIT;
               else                  state <= CAPTURE;
            end

            WAIT: begin
               if (wait_q == WCW'(READ_LATENCY - 2)) state <= CAPTURE;
               else                                   wait_q <= wait_q + 1'b1;
            end

            CAPTURE: begin
               for (int unsigned i = 0; i < SUBPATCHES; i++) begin
                  if (slot_q == SW'(i)) desc_data[i*W +: W] <= desc_read;
               end
               if (slot_q != SW'(SUBPATCHES - 1)) begin
                  slot_q         <= slot_q + 1'b1;
                  desc_read_addr <= base_q + AW'(slot_q) + AW'(1);
                  state          <= ISSUE;
               end else begin
                  desc_valid <= 1'b1;
                  state      <= OUTPUT;
               end
            end

            OUTPUT: begin
               if (desc_ready) begin
                  desc_valid <= 1'b0;
                  slot_q     <= '0;
                  base_q     <= base_q + AW'(SUBPATCHES);
                  // Old base: the next group spans base+SUBPATCHES .. base+2*SUBPATCHES-1.
                  if ({1'b0, base_q} + NEXT_SPAN > {1'b0, count_q}) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     desc_index     <= desc_index + 1'b1;
                     desc_read_addr <= base_q + AW'(SUBPATCHES);
                     state          <= ISSUE;
                  end
               end
            end

            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/descriptor_reader.md
Name: descriptor_reader

Overview:
- Consumer end of the descriptor BRAM written by the descriptor generator.
- The generator writes each keypoint as 4 consecutive 24-bit sub-patch histogram words (8 bins × 3 bits).
- This block reads the words back in order and packs each group of 4 into one 96-bit keypoint descriptor.
- It presents each descriptor on a valid/ready stream for the matching or export stage.

Parameters:
- NUMBER_DESCRIPTORS, 4000, BRAM depth in 24-bit words; address width is $clog2(NUMBER_DESCRIPTORS) = 12.
- BIN_WIDTH, 3, bits per orientation bin.
- NUM_BINS, 8, orientation bins per sub-patch; word width W = BIN_WIDTH*NUM_BINS = 24.
- SUBPATCHES, 4, words per descriptor; descriptor width D = W*SUBPATCHES = 96.
- READ_LATENCY, 2, BRAM read latency in cycles (address to data).

Ports:
- clk  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a readout pass
- desc_count  in  12  number of valid words in BRAM (the generator's final write address); sampled on start
- desc_read_addr  out  12  BRAM read address
- desc_read  in  24  BRAM read data
- desc_valid  out  1  desc_data holds a complete descriptor
- desc_ready  in  1  downstream accepts
- desc_data  out  96  packed descriptor
- desc_index  out  10  index of the descriptor currently on desc_data (0-based)
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous. While rst_in is high:
  - All outputs are 0.
  - FSM is in IDLE.
  - Internal counters and the latched count are 0.
  - This applies at any point, including mid-pass; no partial descriptor survives.
  - The next start always begins at address 0.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, OUTPUT, FINISH.
- IDLE:
  - On start, latch count = desc_count; base = 0; slot = 0; desc_index = 0.
  - If count < 4, go to FINISH. Otherwise go to ISSUE.
  - start is ignored in every state except IDLE.
- ISSUE: desc_read_addr = base + slot (registered); go to WAIT.
- WAIT: hold for READ_LATENCY-1 cycles (wait counter); then go to CAPTURE.
- CAPTURE:
  - desc_data[W*slot +: W] <= desc_read. Sub-patch 0 lands in bits [23:0]; sub-patch 3 lands in [95:72].
  - If slot < 3: slot++ and go to ISSUE.
  - Else: desc_valid <= 1 and go to OUTPUT.
- Per word: ISSUE, then READ_LATENCY-1 WAIT cycles, then CAPTURE, i.e. 1+READ_LATENCY cycles (3 at default).
- With start sampled at cycle 0:
  - The first address is presented at cycle 1.
  - Captures occur at cycles 3, 6, 9, 12.
  - desc_valid is first high at cycle 13.
- OUTPUT:
  - desc_data and desc_index are stable while desc_valid && !desc_ready.
  - Address generation is paused.
  - On desc_valid && desc_ready: desc_valid <= 0; base += 4; slot = 0; desc_index++.
  - After the handshake, if base+8 > count (no complete next group), go to FINISH; else go to ISSUE.
- Trailing words (count mod 4) are never read or emitted.
- FINISH: done = 1 for exactly this one cycle (Moore output); busy = 1; next state IDLE.
- Only an explicit start restarts a pass; there is no auto-restart.
- desc_read_addr never exceeds count-1.
- base arithmetic is 12-bit. count ≤ NUMBER_DESCRIPTORS guarantees no wrap.
- desc_index saturates logically at count/4-1.
- desc_valid never rises in the same cycle as done.

Test Plan:
- Reset: assert rst_in asynchronously mid-cycle → desc_valid, done, busy, desc_read_addr, desc_data all 0 immediately (no clock edge needed).
- Full-rate readout: BRAM words 0x000001..0x000008, count=8, desc_ready held 1, start at cycle 0:
  - First addr at cycle 1; desc_valid high at cycle 13 with desc_data=0x000004_000003_000002_000001, desc_index=0.
  - Second descriptor 0x000008_000007_000006_000005, desc_index=1.
  - done is a single pulse the cycle after the second handshake; busy drops the following cycle.
- Backpressure: same preload, desc_ready low for 5 cycles after the first desc_valid → desc_data, desc_index and desc_read_addr unchanged across those 5 cycles; no second-descriptor address issued until the handshake.
- Partial and empty counts:
  - count=6 → exactly one descriptor (words 0-3); addresses 4,5 never driven; done follows.
  - count=2 → desc_valid never asserts; done high at cycle 1.
- Reset mid-operation: assert rst_in during the WAIT of slot 2 → all outputs 0. A subsequent start with count=4 yields desc_valid at cycle 13 with fresh data from address 0.
- start while busy: pulse start at cycles 5 and 14 of a count=8 pass → ignored; pass completes with exactly two descriptors and one done pulse.
